// File: rtl/keccak_absorb_ctrl.sv
// Absorb-phase front end for the Keccak core: packs 64-bit message words into
// rate-wide blocks, bit-reverses each byte, and applies pad10*1 on the final block.
module keccak_absorb_ctrl #(
  parameter int DOUT_WIDTH = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [63:0]                   in_data,
  input  logic                          in_last,
  input  logic [3:0]                    in_bytes,
  output logic                          blk_valid,
  input  logic                          blk_ready,
  output logic [1600-2*DOUT_WIDTH-1:0]  blk_data,
  output logic                          blk_last
);

  localparam int R     = 1600 - 2*DOUT_WIDTH;
  localparam int WORDS = R / 64;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(WORDS - 1);

  typedef enum logic [1:0] {FILL, EMIT, EXTRA} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            extra_pend;

  logic [3:0]      nb;
  int unsigned     nb_u;
  int unsigned     cnt_u;
  logic [63:0]     stored;
  logic            full_last;
  logic            no_room;
  logic [R-1:0]    nxt;

  function automatic logic [63:0] byterev(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 64; i++)
      r[(i/8)*8 + (7 - (i%8))] = d[i];
    return r;
  endfunction

  // Next buffer image for a word accepted at slot cnt; on the final word the
  // slots past cnt are rewritten with the pad10*1 tail.
  always_comb begin
    nb        = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    nb_u      = 32'(nb);
    cnt_u     = 32'(cnt);
    full_last = in_last && (nb == 4'd8);
    no_room   = full_last && (cnt == LAST_SLOT);
    stored    = byterev(in_data);
    if (in_last) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (i >= nb_u) stored[63-8*i -: 8] = '0;
      end
      for (int unsigned i = 0; i < 8; i++) begin
        if (i == nb_u) stored[63-8*i] = 1'b1;
      end
    end
    nxt = blk_data;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (k == cnt_u)
        nxt[R-1-64*k -: 64] = stored;
      else if (in_last && (k > cnt_u))
        nxt[R-1-64*k -: 64] = (full_last && (k == cnt_u + 1)) ? 64'h8000_0000_0000_0000 : '0;
    end
    if (in_last && !no_room) nxt[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FILL;
      cnt        <= '0;
      extra_pend <= 1'b0;
      in_ready   <= 1'b0;
      blk_valid  <= 1'b0;
      blk_last   <= 1'b0;
      blk_data   <= '0;
    end else begin
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            blk_data <= nxt;
            if (in_last || (cnt == LAST_SLOT)) begin
              state      <= EMIT;
              in_ready   <= 1'b0;
              blk_valid  <= 1'b1;
              cnt        <= '0;
              blk_last   <= in_last && !no_room;
              extra_pend <= no_room;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        EMIT: begin
          if (blk_ready) begin
            blk_valid <= 1'b0;
            if (extra_pend) begin
              state <= EXTRA;
            end else begin
              state    <= FILL;
              blk_data <= '0;
              blk_last <= 1'b0;
              cnt      <= '0;
              in_ready <= 1'b1;
            end
          end
        end
        EXTRA: begin
          blk_data   <= {1'b1, {(R-2){1'b0}}, 1'b1};
          blk_last   <= 1'b1;
          extra_pend <= 1'b0;
          blk_valid  <= 1'b1;
          state      <= EMIT;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
